// File: rtl/msu_pkg.sv
// Shared types for the modular squaring unit and its host-side controller.
package msu_pkg;

  localparam int unsigned TotalWordBits = 32;

  typedef logic [TotalWordBits-1:0] msu_word_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    DRAIN,
    RESP
  } msu_ctrl_state_e;

  typedef enum logic [1:0] {
    OK      = 2'b00,
    ABORTED = 2'b01,
    TIMEOUT = 2'b10
  } msu_ctrl_status_e;

endpackage

// File: rtl/msu_ctrl.sv
// Host-side job controller for the MSU: launch, count squarings, stop, and report a response.
// Optional run watchdog enabled by defining MSU_CTRL_TIMEOUT_EN.
module msu_ctrl
  import msu_pkg::*;
#(
  parameter int unsigned IterBits      = 64,
  parameter int unsigned DrainCycles   = 3,
  parameter int unsigned TimeoutCycles = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [TotalWordBits-1:0] req_nr_i,
  input  logic [TotalWordBits-1:0] req_r_i,
  input  logic [IterBits-1:0]      req_iter_i,
  input  logic                     abort_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [TotalWordBits-1:0] rsp_nr_o,
  output logic [TotalWordBits-1:0] rsp_r_o,
  output logic [IterBits-1:0]      rsp_iter_o,
  output logic [1:0]               rsp_status_o,
  output logic                     busy_o,
  output logic                     msu_start_o,
  output logic                     msu_stop_o,
  output logic [TotalWordBits-1:0] msu_nr_o,
  output logic [TotalWordBits-1:0] msu_r_o,
  input  logic                     msu_valid_i,
  input  logic [TotalWordBits-1:0] msu_nr_i,
  input  logic [TotalWordBits-1:0] msu_r_i
);

  localparam int unsigned DrainBits = $clog2(DrainCycles + 1);

  msu_ctrl_state_e      r_state, w_state_d;
  msu_ctrl_status_e     r_status, w_status_d;
  logic [DrainBits-1:0] r_drain, w_drain_d;
  logic                 r_drain_to_idle, w_drain_to_idle_d;
  msu_word_t            r_nr, r_r;
  logic [IterBits-1:0]  r_iter, r_cnt;
  logic                 w_accept, w_last, w_timeout;

  assign w_accept = (r_state == IDLE) && req_valid_i;
  // The N-th pulse: stop must coincide with it so the MSU loop ends on this square.
  assign w_last   = (r_state == RUN) && msu_valid_i && (r_cnt == r_iter - IterBits'(1));

`ifdef MSU_CTRL_TIMEOUT_EN
  localparam int unsigned WdogBits = $clog2(TimeoutCycles + 1);
  logic [WdogBits-1:0] r_wdog;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wdog <= '0;
    end else if (r_state == LAUNCH || msu_valid_i) begin
      r_wdog <= '0;
    end else if (r_state == RUN) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  // A pulse in the expiry cycle wins over the timeout.
  assign w_timeout = (r_state == RUN) && !msu_valid_i &&
                     (r_wdog == WdogBits'(TimeoutCycles - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= DRAIN;
      r_status        <= OK;
      r_drain         <= DrainBits'(DrainCycles);
      r_drain_to_idle <= 1'b1;
    end else begin
      r_state         <= w_state_d;
      r_status        <= w_status_d;
      r_drain         <= w_drain_d;
      r_drain_to_idle <= w_drain_to_idle_d;
    end
  end

  always_comb begin
    w_state_d         = r_state;
    w_status_d        = r_status;
    w_drain_d         = r_drain;
    w_drain_to_idle_d = r_drain_to_idle;
    unique case (r_state)
      IDLE: begin
        if (req_valid_i) begin
          w_status_d = OK;
          if (req_iter_i == '0) begin
            w_state_d = RESP;
          end else begin
            w_state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        if (abort_i) begin
          w_state_d         = DRAIN;
          w_status_d        = ABORTED;
          w_drain_d         = DrainBits'(DrainCycles);
          w_drain_to_idle_d = 1'b0;
        end else begin
          w_state_d = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_d  = RESP;
          w_status_d = OK;
        end else if (abort_i || w_timeout) begin
          w_state_d         = DRAIN;
          w_status_d        = abort_i ? ABORTED : TIMEOUT;
          w_drain_d         = DrainBits'(DrainCycles);
          w_drain_to_idle_d = 1'b0;
        end
      end
      DRAIN: begin
        if (r_drain <= DrainBits'(1)) begin
          if (r_drain_to_idle) begin
            w_state_d = IDLE;
          end else begin
            w_state_d = RESP;
          end
        end else begin
          w_drain_d = r_drain - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // One value register serves as MSU seed until the first capture, then as last square.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_nr   <= '0;
      r_r    <= '0;
      r_iter <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_nr   <= req_nr_i;
      r_r    <= req_r_i;
      r_iter <= req_iter_i;
      r_cnt  <= '0;
    end else if (r_state == RUN && msu_valid_i) begin
      r_nr  <= msu_nr_i;
      r_r   <= msu_r_i;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign req_ready_o  = (r_state == IDLE);
  assign busy_o       = (r_state != IDLE);
  assign rsp_valid_o  = (r_state == RESP);
  assign msu_start_o  = (r_state == LAUNCH);
  assign msu_stop_o   = (r_state == DRAIN) || w_last;
  assign msu_nr_o     = r_nr;
  assign msu_r_o      = r_r;
  assign rsp_nr_o     = r_nr;
  assign rsp_r_o      = r_r;
  assign rsp_iter_o   = r_cnt;
  assign rsp_status_o = r_status;

endmodule
